// File: rtl/puf_selector_if.sv
// Racing-line bundle for one arbiter-PUF switch stage.
// Carries the challenge controls, the two paths and the latched challenge.
interface puf_selector_if #(
    parameter int LINE_W = 1
);
    logic                  challenge;
    logic                  chal_load;
    logic [2*LINE_W-1:0]   i_line;
    logic [2*LINE_W-1:0]   o_line;
    logic                  chal_q;
    logic                  chal_valid;

    modport master (
        output challenge,
        output chal_load,
        output i_line,
        input  o_line,
        input  chal_q,
        input  chal_valid
    );

    modport slave (
        input  challenge,
        input  chal_load,
        input  i_line,
        output o_line,
        output chal_q,
        output chal_valid
    );
endinterface

// File: rtl/puf_selector.sv
// Arbiter-PUF switch stage: straight/crossed routing of two racing paths.
// SELECTOR_OUT_REG_EN registers o_line (debug/functional sim builds only).
module puf_selector #(
    parameter int LINE_W = 1
) (
    input  logic           CLK,
    input  logic           RST_N,
    puf_selector_if.slave  bus
);
    logic                  chal_r;
    logic                  valid_r;
    logic [LINE_W-1:0]     p0;
    logic [LINE_W-1:0]     p1;
    logic [2*LINE_W-1:0]   route;

    // Latch the challenge so routing only changes on a clock edge
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            chal_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (bus.chal_load) begin
            chal_r  <= bus.challenge;
            valid_r <= 1'b1;
        end
    end

    assign p0 = bus.i_line[LINE_W-1:0];
    assign p1 = bus.i_line[2*LINE_W-1:LINE_W];

    // Two mirrored 2:1 muxes so both race paths see the same structure
    assign route[LINE_W-1:0]        = chal_r ? p1 : p0;
    assign route[2*LINE_W-1:LINE_W] = chal_r ? p0 : p1;

`ifdef SELECTOR_OUT_REG_EN
    logic [2*LINE_W-1:0]   o_q;

    // Sample the routed paths for debug visibility
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            o_q <= '0;
        end else begin
            o_q <= route;
        end
    end

    assign bus.o_line = o_q;
`else
    assign bus.o_line = route;
`endif

    assign bus.chal_q     = chal_r;
    assign bus.chal_valid = valid_r;
endmodule

// File: tb/tb_puf_selector.sv
// Directed bench for puf_selector, narrow (LINE_W=1) and wide (LINE_W=4).
// Expectations follow whichever o_line mode the build selects.
module tb_puf_selector;
    logic CLK;
    logic RST_N;
    int   n_cmp;
    int   n_bad;

    puf_selector_if #(.LINE_W(1)) b1 ();
    puf_selector_if #(.LINE_W(4)) b4 ();

    puf_selector #(.LINE_W(1)) dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (b1)
    );

    puf_selector #(.LINE_W(4)) dut4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (b4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_chal(input logic c, input logic ld);
        b1.challenge = c;
        b4.challenge = c;
        b1.chal_load = ld;
        b4.chal_load = ld;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST_N = 1'b0;
        set_chal(1'b1, 1'b1);
        b1.i_line = 2'b01;
        b4.i_line = 8'hA5;

        // reset held two cycles with load asserted
        step();
        step();
        check("rst_chal_q", b1.chal_q, 0);
        check("rst_valid", b1.chal_valid, 0);
        check("rst_valid_w", b4.chal_valid, 0);
`ifdef SELECTOR_OUT_REG_EN
        check("rst_o_line", b1.o_line, 8'h00);
`else
        check("rst_o_line", b1.o_line, 8'h01);
`endif

        // straight route
        RST_N = 1'b1;
        set_chal(1'b0, 1'b1);
        step();
        check("str_valid", b1.chal_valid, 1);
        check("str_chal_q", b1.chal_q, 0);
        check("str_o_line", b1.o_line, 8'h01);
        check("str_wide", b4.o_line, 8'hA5);

        // i_line to o_line latency
        b1.i_line = 2'b10;
        #1;
`ifdef SELECTOR_OUT_REG_EN
        check("lat_hold", b1.o_line, 8'h01);
`else
        check("lat_comb", b1.o_line, 8'h02);
`endif
        step();
        check("lat_after", b1.o_line, 8'h02);

        // reset on the edge where i_line changes
        b1.i_line = 2'b01;
        RST_N = 1'b0;
        step();
        check("rst2_valid", b1.chal_valid, 0);
`ifdef SELECTOR_OUT_REG_EN
        check("rst2_o_line", b1.o_line, 8'h00);
`else
        check("rst2_o_line", b1.o_line, 8'h01);
`endif
        RST_N = 1'b1;
        step();
        check("rel_valid", b1.chal_valid, 1);

        // crossed route, one-cycle load pulse
        set_chal(1'b1, 1'b1);
        step();
        check("x_chal_q", b1.chal_q, 1);
`ifdef SELECTOR_OUT_REG_EN
        check("x_first", b1.o_line, 8'h01);
`else
        check("x_first", b1.o_line, 8'h02);
`endif
        set_chal(1'b1, 1'b0);
        step();
        check("x_01", b1.o_line, 8'h02);
        check("x_wide", b4.o_line, 8'h5A);
        b1.i_line = 2'b10;
        step();
        check("x_10", b1.o_line, 8'h01);
        b1.i_line = 2'b11;
        step();
        check("x_11", b1.o_line, 8'h03);

        // hold: challenge toggles without load
        b1.i_line = 2'b01;
        for (int i = 0; i < 5; i++) begin
            set_chal(i[0], 1'b0);
            step();
            check("hold_chal_q", b1.chal_q, 1);
            check("hold_o_line", b1.o_line, 8'h02);
        end
        check("hold_wide", b4.o_line, 8'h5A);

        // mid-operation reset forces straight routing
        RST_N = 1'b0;
        step();
        check("mid_chal_q", b1.chal_q, 0);
        check("mid_valid", b1.chal_valid, 0);
`ifdef SELECTOR_OUT_REG_EN
        check("mid_o_line", b1.o_line, 8'h00);
`else
        check("mid_o_line", b1.o_line, 8'h01);
`endif
        RST_N = 1'b1;
        step();
        check("post_o_line", b1.o_line, 8'h01);
        check("post_valid", b1.chal_valid, 0);
        check("post_wide", b4.o_line, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/puf_selector.md
# puf_selector

Single switch stage of an arbiter-PUF delay chain. It routes two racing input lines to two output lines, either straight or crossed, according to a registered challenge bit. Stages are cascaded output-to-input between the trigger source and the arbiter. The challenge bit is latched on CLK so the routing is stable before a race edge is launched.

## Interface
Parameters:
- LINE_W, default 1: bits carried per path. `i_line` and `o_line` are 2*LINE_W wide. Path 0 is the low LINE_W bits; path 1 is the high LINE_W bits.

Ports:
- CLK  in  1  system clock, rising-edge active.
- RST_N  in  1  one clock; reset is synchronous and active-low.
- challenge  in  1  challenge bit for this stage. 0 routes straight; 1 routes crossed.
- chal_load  in  1  challenge capture strobe; tie to 1 to track `challenge` every cycle.
- i_line  in  2*LINE_W  racing input paths {path1, path0}.
- o_line  out  2*LINE_W  routed output paths {path1, path0}.
- chal_q  out  1  currently applied (latched) challenge.
- chal_valid  out  1  high once a challenge has been loaded since reset.

## Operation
- Challenge register `chal_q`:
  - On a CLK rising edge with RST_N=0: chal_q←0 and chal_valid←0.
  - Otherwise, if chal_load=1: chal_q←challenge and chal_valid←1.
  - Otherwise both hold their values.
- Routing uses `chal_q`, never the raw `challenge` input:
  - chal_q=0: o_line[path0]=i_line[path0] and o_line[path1]=i_line[path1].
  - chal_q=1: o_line[path0]=i_line[path1] and o_line[path1]=i_line[path0].
- The data path has no logic other than the 2:1 muxes. Both muxes must be structurally identical so the two path delays are symmetric; the small mismatch between them is the PUF entropy.
- All LINE_W bits of a path are routed together; bits never mix across bit positions.
- No state machine. The only state is chal_q and chal_valid, plus the output register when the Configuration macro is defined.
- Changing the challenge while a race edge is in flight is a user error. The block guarantees only that the route changes exactly at a CLK edge.

## Timing
- Challenge-to-route latency: 1 cycle. A `challenge` value sampled at edge N governs routing from just after edge N.
- i_line→o_line:
  - Combinational (zero cycles) by default.
  - 1 cycle when the Configuration macro is defined.
- Reset values:
  - chal_q=0 and chal_valid=0, so routing is straight.
  - Without the macro, o_line follows i_line straight.
  - With the macro, the registered o_line is 0.
- Reset has priority over chal_load on the same edge.
- A reset asserted mid-operation forces straight routing from the next edge.

## Configuration
- Macro SELECTOR_OUT_REG_EN:
  - Defined: o_line is registered on CLK and is reset to 0 by RST_N. This mode is used for functional simulation and for sampling stage outputs for debug.
  - Undefined (the default for PUF builds): o_line is purely combinational from i_line and chal_q, and no flops exist in the race path.

## Test plan
- Reset: hold RST_N=0 for 2 cycles with challenge=1 and chal_load=1 → chal_q=0, chal_valid=0; with i_line=2'b01, o_line=2'b01.
- Straight route: release reset, challenge=0, chal_load=1, i_line=2'b01 → after 1 edge chal_valid=1 and o_line=2'b01.
- Crossed route: challenge=1 and chal_load pulsed for one cycle, then i_line=2'b01 → o_line=2'b10; i_line=2'b10 → o_line=2'b01; with i_line=2'b11 driving both paths from the same trigger, o_line=2'b11.
- Hold: chal_load=0 while challenge toggles 0↔1 for 5 cycles → chal_q and the routing stay unchanged.
- Wide paths: LINE_W=4, chal_q=1, i_line=8'hA5 → o_line=8'h5A.
- SELECTOR_OUT_REG_EN defined: i_line changes 2'b01→2'b10 with chal_q=0 → o_line updates exactly one cycle later; with RST_N=0 on that edge, o_line=0.
